// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter between the CPU data
// port (C) and the loader/DMA port (D).
package dram_arb_pkg;

  typedef enum logic {ARB, BURST} arb_state_e;

  localparam int WAIT_W = 4;
  localparam int BEAT_W = 8;

  localparam int PORT_C = 0;
  localparam int PORT_D = 1;

endpackage

// File: rtl/dram_arbiter.sv
// Single-port dram arbiter: C has fixed priority, D gets starvation relief
// after MAX_WAIT denied cycles and may lock the RAM for up to MAX_BURST beats.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic          i_clk,
  input  logic          i_rstb,
  input  logic          i_clk_en,
  input  logic          i_c_req,
  input  logic          i_c_we,
  input  logic [AW-1:0] i_c_addr,
  input  logic [DW-1:0] i_c_wdata,
  output logic          o_c_gnt,
  output logic          o_c_rvalid,
  output logic [DW-1:0] o_c_rdata,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic          i_d_lock,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_gnt,
  output logic          o_d_rvalid,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_ram_cs,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);

  arb_state_e        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt, beat_inc;
  logic              force_c, force_nxt;
  logic              active, burst_hold, d_win;
  logic [1:0]        gnt;
  logic              c_rvalid_p1, d_rvalid_p1;

  // Stage p0: combinational grant and next-state decode
  always_comb begin
    active     = i_clk_en & i_rstb;
    burst_hold = (state == BURST) & i_d_req;
    // force_c gives C the cycle right after a forced burst release
    d_win      = i_d_req & (burst_hold | !i_c_req |
                            (!force_c & (wait_cnt == WAIT_MAX)));
    gnt = '0;
    if (active) begin
      if (d_win)        gnt[PORT_D] = 1'b1;
      else if (i_c_req) gnt[PORT_C] = 1'b1;
    end

    state_nxt = state;
    wait_nxt  = wait_cnt;
    beat_nxt  = beat_cnt;
    force_nxt = 1'b0;
    beat_inc  = beat_cnt + BEAT_W'(1);

    if (!i_d_req || gnt[PORT_D]) wait_nxt = '0;
    else if (wait_cnt != WAIT_MAX) wait_nxt = wait_cnt + WAIT_W'(1);

    case (state)
      ARB: begin
        if (gnt[PORT_D] && i_d_lock) begin
          state_nxt = BURST;
          beat_nxt  = BEAT_W'(1);
        end
      end
      BURST: begin
        if (!i_d_req) begin
          state_nxt = ARB;
        end else begin
          beat_nxt = beat_inc;
          if (!i_d_lock) begin
            state_nxt = ARB;
          end else if (beat_inc == BEAT_MAX) begin
            state_nxt = ARB;
            force_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      state       <= ARB;
      wait_cnt    <= '0;
      beat_cnt    <= '0;
      force_c     <= 1'b0;
      c_rvalid_p1 <= 1'b0;
      d_rvalid_p1 <= 1'b0;
    end else if (i_clk_en) begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      beat_cnt    <= beat_nxt;
      force_c     <= force_nxt;
      c_rvalid_p1 <= gnt[PORT_C] & !i_c_we;
      d_rvalid_p1 <= gnt[PORT_D] & !i_d_we;
    end
  end

  // Stage p1: read return; data comes straight from the RAM, qualified by rvalid
  assign o_c_gnt     = gnt[PORT_C];
  assign o_d_gnt     = gnt[PORT_D];
  assign o_ram_cs    = |gnt;
  assign o_ram_we    = gnt[PORT_D] ? i_d_we    : i_c_we;
  assign o_ram_addr  = gnt[PORT_D] ? i_d_addr  : i_c_addr;
  assign o_ram_wdata = gnt[PORT_D] ? i_d_wdata : i_c_wdata;
  assign o_c_rvalid  = c_rvalid_p1;
  assign o_d_rvalid  = d_rvalid_p1;
  assign o_c_rdata   = i_ram_rdata;
  assign o_d_rdata   = i_ram_rdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: table of per-cycle vectors plus hand
// sequences for forced burst release, clock-enable stall and reset mid-burst.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rstb, clk_en;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [11:0] c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        ram_cs, ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dram_arbiter #(.AW(12), .DW(32), .MAX_WAIT(4), .MAX_BURST(8)) dut (
    .i_clk(clk), .i_rstb(rstb), .i_clk_en(clk_en),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_lock(d_lock), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_ram_cs(ram_cs), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  // RAM model: word i holds 0xA5A5_0000|i except two marked words
  logic [31:0] mem [4096];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      mem[12'h010] <= 32'h1234_5678;
      mem[12'h020] <= 32'hCAFE_0001;
      mem_init     <= 1'b1;
    end else if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        rstb, en;
    logic        c_req, c_we;
    logic [11:0] c_addr;
    logic        d_req, d_we, d_lock;
    logic [11:0] d_addr;
    logic        e_cg, e_dg, e_crv, e_drv;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic rs, en, cr, cw, input logic [11:0] ca,
                              input logic dr, dw, dl, input logic [11:0] da,
                              input logic ecg, edg, ecrv, edrv,
                              input logic [31:0] erd);
    vec_t v;
    v.rstb = rs;  v.en = en;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca;
    v.d_req = dr; v.d_we = dw; v.d_lock = dl; v.d_addr = da;
    v.e_cg = ecg; v.e_dg = edg; v.e_crv = ecrv; v.e_drv = edrv;
    v.e_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string name, input string tag,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%s: got %h, want %h", name, tag, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [11:0] ea;
    rstb = v.rstb;  clk_en = v.en;
    c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr;
    c_wdata = {20'hC0DE0, v.c_addr};
    d_req = v.d_req; d_we = v.d_we; d_lock = v.d_lock; d_addr = v.d_addr;
    d_wdata = {20'hD0D0D, v.d_addr};
    @(negedge clk);
    chk("c_gnt", tag, 32'(c_gnt), 32'(v.e_cg));
    chk("d_gnt", tag, 32'(d_gnt), 32'(v.e_dg));
    chk("ram_cs", tag, 32'(ram_cs), 32'(v.e_cg | v.e_dg));
    if (v.e_cg | v.e_dg) begin
      ea = v.e_dg ? v.d_addr : v.c_addr;
      chk("ram_addr", tag, 32'(ram_addr), 32'(ea));
      chk("ram_we", tag, 32'(ram_we), 32'(v.e_dg ? v.d_we : v.c_we));
      chk("ram_wdata", tag, ram_wdata, v.e_dg ? d_wdata : c_wdata);
    end
    chk("c_rvalid", tag, 32'(c_rvalid), 32'(v.e_crv));
    chk("d_rvalid", tag, 32'(d_rvalid), 32'(v.e_drv));
    if (v.e_crv) chk("c_rdata", tag, c_rdata, v.e_rdata);
    if (v.e_drv) chk("d_rdata", tag, d_rdata, v.e_rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    rstb = 1'b0; clk_en = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = '0; d_wdata = '0;
    @(posedge clk);
    #1;

    // reset state: requests present but nothing granted
    tbl.push_back(mk(0,1, 1,0,12'h010, 1,0,0,12'h200, 0,0,0,0, 0));
    // C read, D idle: grant now, data next cycle, single pulse
    tbl.push_back(mk(1,1, 1,0,12'h010, 0,0,0,12'h000, 1,0,0,0, 0));
    tbl.push_back(mk(1,1, 0,0,12'h000, 0,0,0,12'h000, 0,0,1,0, 32'h1234_5678));
    tbl.push_back(mk(1,1, 0,0,12'h000, 0,0,0,12'h000, 0,0,0,0, 0));
    // both request continuously: C,C,C,C,D repeating
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9)
        tbl.push_back(mk(1,1, 1,1,12'h100, 1,1,0,12'h200, 0,1,0,0, 0));
      else
        tbl.push_back(mk(1,1, 1,1,12'h100, 1,1,0,12'h200, 1,0,0,0, 0));
    end
    tbl.push_back(mk(1,1, 0,0,12'h000, 0,0,0,12'h000, 0,0,0,0, 0));
    // locked 3-beat D write burst blocks C, C wins right after
    tbl.push_back(mk(1,1, 0,0,12'h000, 1,1,1,12'h300, 0,1,0,0, 0));
    tbl.push_back(mk(1,1, 1,1,12'h104, 1,1,1,12'h301, 0,1,0,0, 0));
    tbl.push_back(mk(1,1, 1,1,12'h104, 1,1,0,12'h302, 0,1,0,0, 0));
    tbl.push_back(mk(1,1, 1,1,12'h104, 0,0,0,12'h000, 1,0,0,0, 0));
    tbl.push_back(mk(1,1, 0,0,12'h000, 0,0,0,12'h000, 0,0,0,0, 0));
    // idle burst: D drops req, C served in the same cycle
    tbl.push_back(mk(1,1, 0,0,12'h000, 1,1,1,12'h310, 0,1,0,0, 0));
    tbl.push_back(mk(1,1, 1,1,12'h105, 0,0,0,12'h000, 1,0,0,0, 0));
    tbl.push_back(mk(1,1, 0,0,12'h000, 0,0,0,12'h000, 0,0,0,0, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

    // forced release after MAX_BURST=8 locked beats
    apply(mk(1,1, 0,0,12'h000, 1,1,1,12'h400, 0,1,0,0, 0), "brst1");
    for (int b = 2; b <= 8; b++)
      apply(mk(1,1, 1,1,12'h101, 1,1,1,12'h400 + 12'(b), 0,1,0,0, 0),
            $sformatf("brst%0d", b));
    apply(mk(1,1, 1,1,12'h101, 1,1,1,12'h409, 1,0,0,0, 0), "release_c");
    apply(mk(1,1, 0,0,12'h000, 1,1,1,12'h40A, 0,1,0,0, 0), "reenter");
    apply(mk(1,1, 1,1,12'h101, 1,1,1,12'h40B, 0,1,0,0, 0), "reburst");
    apply(mk(1,1, 0,0,12'h000, 1,1,0,12'h40C, 0,1,0,0, 0), "reburst_end");
    apply(mk(1,1, 0,0,12'h000, 0,0,0,12'h000, 0,0,0,0, 0), "brst_idle");

    // D read then 3-cycle clock-enable stall with requests pending
    apply(mk(1,1, 0,0,12'h000, 1,0,0,12'h020, 0,1,0,0, 0), "stall_rd");
    for (int s = 0; s < 3; s++)
      apply(mk(1,0, 1,1,12'h102, 1,0,0,12'h021, 0,0,0,1, 32'hCAFE_0001),
            $sformatf("stall%0d", s));
    apply(mk(1,1, 1,1,12'h102, 1,0,0,12'h021, 1,0,0,1, 32'hCAFE_0001), "resume0");
    for (int s = 1; s < 4; s++)
      apply(mk(1,1, 1,1,12'h102, 1,0,0,12'h021, 1,0,0,0, 0),
            $sformatf("resume%0d", s));
    apply(mk(1,1, 1,1,12'h102, 1,0,0,12'h021, 0,1,0,0, 0), "resume_d");
    apply(mk(1,1, 0,0,12'h000, 0,0,0,12'h000, 0,0,0,1, 32'hA5A5_0021), "resume_rv");

    // reset in the middle of a locked read burst with a read in flight
    apply(mk(1,1, 0,0,12'h000, 1,0,1,12'h020, 0,1,0,0, 0), "rb1");
    apply(mk(1,1, 1,1,12'h103, 1,0,1,12'h021, 0,1,0,1, 32'hCAFE_0001), "rb2");
    apply(mk(0,1, 1,1,12'h103, 1,0,1,12'h022, 0,0,0,1, 32'hA5A5_0021), "rb_rst");
    apply(mk(1,1, 1,0,12'h010, 1,1,0,12'h202, 1,0,0,0, 0), "post_rst0");
    for (int s = 1; s < 4; s++)
      apply(mk(1,1, 1,0,12'h010, 1,1,0,12'h202, 1,0,1,0, 32'h1234_5678),
            $sformatf("post_rst%0d", s));
    apply(mk(1,1, 1,0,12'h010, 1,1,0,12'h202, 0,1,1,0, 32'h1234_5678), "post_rst_d");
    apply(mk(1,1, 0,0,12'h000, 0,0,0,12'h000, 0,0,0,0, 0), "post_rst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
